// File: rtl/adc_spi_pkg.sv
// Shared constants and FSM state encodings for the ADC/preamp SPI responder.
package adc_spi_pkg;

  localparam int DATA_W    = 14;
  localparam int FRAME_LEN = 34;
  localparam int GAIN_W    = 8;

  // Frame field boundaries, in rising-edge numbers: a field covers (START, END].
  localparam int FIELD_A_START = 2;
  localparam int FIELD_A_END   = 16;
  localparam int FIELD_B_START = 18;
  localparam int FIELD_B_END   = 32;

  localparam int EDGE_CNT_W = 6;
  localparam int AMP_CNT_W  = 4;

  typedef enum logic [1:0] {
    AMP_IDLE  = 2'd0,
    AMP_SHIFT = 2'd1,
    AMP_LATCH = 2'd2
  } amp_state_t;

  typedef enum logic [1:0] {
    ADC_IDLE  = 2'd0,
    ADC_FRAME = 2'd1,
    ADC_DONE  = 2'd2
  } adc_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates a dual-channel serial ADC plus an SPI-programmed preamp: shifts in
// gain commands while amp_cs is low and serves sample frames after adc_conv.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W    = adc_spi_pkg::DATA_W,
  parameter int FRAME_LEN = adc_spi_pkg::FRAME_LEN,
  parameter int GAIN_W    = adc_spi_pkg::GAIN_W
) (
  input  logic                  clk,
  input  logic                  enable,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  amp_cs,
  input  logic                  amp_shdn,
  input  logic                  adc_conv,
  input  logic [DATA_W-1:0]     sample_a,
  input  logic [DATA_W-1:0]     sample_b,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [GAIN_W/2-1:0]   gain_a,
  output logic [GAIN_W/2-1:0]   gain_b,
  output logic                  gain_valid,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  protocol_err,
  output logic [15:0]           conv_count
);

  localparam int IDX_W = $clog2(DATA_W);

  logic sck_rise, sck_fall, sck_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic conv_rise, conv_level_unused, conv_fall_unused;

  spi_edge_sync u_sync_sck  (.clk(clk), .rst(enable), .din(spi_sck),
                             .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall));
  spi_edge_sync u_sync_mosi (.clk(clk), .rst(enable), .din(spi_mosi),
                             .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  spi_edge_sync u_sync_cs   (.clk(clk), .rst(enable), .din(amp_cs),
                             .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync u_sync_conv (.clk(clk), .rst(enable), .din(adc_conv),
                             .level(conv_level_unused), .rise(conv_rise), .fall(conv_fall_unused));

  amp_state_t             amp_state, amp_next;
  logic [GAIN_W-1:0]      amp_shift;
  logic [AMP_CNT_W-1:0]   amp_cnt;
  logic                   amp_clr, amp_shift_en, latch_ok, latch_bad;

  adc_state_t             adc_state, adc_next;
  logic [EDGE_CNT_W-1:0]  edge_k, nxt_k, a_off, b_off;
  logic [DATA_W-1:0]      cap_a, cap_b;
  logic                   capture, k_inc, drive_upd, count_inc;
  logic                   bit_oe, bit_val;

  // Preamp state register.
  always_ff @(posedge clk or posedge enable) begin
    if (enable) amp_state <= AMP_IDLE;
    else        amp_state <= amp_next;
  end

  // Preamp sequencing; shutdown parks the FSM and suppresses every outcome.
  always_comb begin
    amp_next     = amp_state;
    amp_clr      = 1'b0;
    amp_shift_en = 1'b0;
    latch_ok     = 1'b0;
    latch_bad    = 1'b0;
    if (amp_shdn) begin
      amp_next = AMP_IDLE;
    end else begin
      case (amp_state)
        AMP_IDLE: begin
          if (cs_fall) begin
            amp_next = AMP_SHIFT;
            amp_clr  = 1'b1;
          end
        end
        AMP_SHIFT: begin
          if (cs_rise)       amp_next     = AMP_LATCH;
          else if (sck_rise) amp_shift_en = 1'b1;
        end
        AMP_LATCH: begin
          amp_next = AMP_IDLE;
          if (amp_cnt == AMP_CNT_W'(GAIN_W)) latch_ok  = 1'b1;
          else                               latch_bad = 1'b1;
        end
        default: amp_next = AMP_IDLE;
      endcase
    end
  end

  // Command shift register, saturating bit counter, gain latches and pulses.
  always_ff @(posedge clk or posedge enable) begin
    if (enable) begin
      amp_shift    <= '0;
      amp_cnt      <= '0;
      gain_a       <= '0;
      gain_b       <= '0;
      gain_valid   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      gain_valid   <= latch_ok;
      protocol_err <= latch_bad;
      if (amp_shdn) begin
        gain_a <= '0;
        gain_b <= '0;
      end else if (latch_ok) begin
        gain_b <= amp_shift[GAIN_W-1:GAIN_W/2];
        gain_a <= amp_shift[GAIN_W/2-1:0];
      end
      if (amp_clr) begin
        amp_shift <= '0;
        amp_cnt   <= '0;
      end else if (amp_shift_en) begin
        amp_shift <= {amp_shift[GAIN_W-2:0], mosi_level};
        if (amp_cnt != '1) amp_cnt <= amp_cnt + AMP_CNT_W'(1);
      end
    end
  end

  // ADC state register.
  always_ff @(posedge clk or posedge enable) begin
    if (enable) adc_state <= ADC_IDLE;
    else        adc_state <= adc_next;
  end

  // ADC framing; a conversion edge always wins over a coincident sck edge.
  always_comb begin
    adc_next  = adc_state;
    capture   = 1'b0;
    k_inc     = 1'b0;
    drive_upd = 1'b0;
    count_inc = 1'b0;
    if (conv_rise) begin
      adc_next = ADC_FRAME;
      capture  = 1'b1;
    end else begin
      case (adc_state)
        ADC_IDLE: adc_next = ADC_IDLE;
        ADC_FRAME: begin
          if (sck_rise) begin
            k_inc = 1'b1;
            if (edge_k == EDGE_CNT_W'(FRAME_LEN - 1)) begin
              adc_next  = ADC_DONE;
              count_inc = 1'b1;
            end
          end else if (sck_fall) begin
            drive_upd = 1'b1;
          end
        end
        ADC_DONE: adc_next = ADC_IDLE;
        default:  adc_next = ADC_IDLE;
      endcase
    end
  end

  assign nxt_k = edge_k + EDGE_CNT_W'(1);

  // Selects the bit the master will sample on the upcoming rising edge.
  always_comb begin
    bit_oe  = 1'b0;
    bit_val = 1'b0;
    a_off   = EDGE_CNT_W'(FIELD_A_END) - nxt_k;
    b_off   = EDGE_CNT_W'(FIELD_B_END) - nxt_k;
    if (nxt_k > EDGE_CNT_W'(FIELD_A_START) && nxt_k <= EDGE_CNT_W'(FIELD_A_END)) begin
      bit_oe  = 1'b1;
      bit_val = cap_a[a_off[IDX_W-1:0]];
    end else if (nxt_k > EDGE_CNT_W'(FIELD_B_START) && nxt_k <= EDGE_CNT_W'(FIELD_B_END)) begin
      bit_oe  = 1'b1;
      bit_val = cap_b[b_off[IDX_W-1:0]];
    end
  end

  // Sample capture, edge counter, output driver and completed-frame count.
  always_ff @(posedge clk or posedge enable) begin
    if (enable) begin
      cap_a       <= '0;
      cap_b       <= '0;
      edge_k      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      conv_count  <= '0;
    end else begin
      if (capture) begin
        cap_a       <= sample_a;
        cap_b       <= sample_b;
        edge_k      <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        if (k_inc) edge_k <= nxt_k;
        if (drive_upd) begin
          spi_miso    <= bit_val;
          spi_miso_oe <= bit_oe;
        end else if (adc_state != ADC_FRAME) begin
          spi_miso    <= 1'b0;
          spi_miso_oe <= 1'b0;
        end
      end
      if (count_inc) conv_count <= conv_count + 16'd1;
    end
  end

  assign busy       = (adc_state != ADC_IDLE);
  assign frame_done = (adc_state == ADC_DONE);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench: table of preamp commands plus scoreboarded ADC frames
// (normal, aborted/restarted, reset mid-frame).
`timescale 1ns/1ps
module tb_adc_spi_responder;

  localparam int HALF = 25;

  logic        clk;
  logic        enable;
  logic        spi_sck;
  logic        spi_mosi;
  logic        amp_cs;
  logic        amp_shdn;
  logic        adc_conv;
  logic [13:0] sample_a;
  logic [13:0] sample_b;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [3:0]  gain_a;
  logic [3:0]  gain_b;
  logic        gain_valid;
  logic        frame_done;
  logic        busy;
  logic        protocol_err;
  logic [15:0] conv_count;

  adc_spi_responder dut (
    .clk(clk), .enable(enable), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .amp_cs(amp_cs), .amp_shdn(amp_shdn), .adc_conv(adc_conv),
    .sample_a(sample_a), .sample_b(sample_b), .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe), .gain_a(gain_a), .gain_b(gain_b),
    .gain_valid(gain_valid), .frame_done(frame_done), .busy(busy),
    .protocol_err(protocol_err), .conv_count(conv_count)
  );

  typedef struct {
    logic [7:0] cmd;
    int         nbits;
    logic       shdn;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    int         exp_valid;
    int         exp_err;
  } amp_vec_t;

  typedef struct packed {
    logic oe;
    logic d;
  } miso_exp_t;

  amp_vec_t    vecs [7];
  miso_exp_t   sb_q [$];
  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic [13:0] got_a;
  logic [13:0] got_b;

  // Free-running system clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (gain_valid)   n_valid++;
    if (protocol_err) n_err++;
    if (frame_done)   n_done++;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic miso_exp_t frame_bit_model(int k, logic [13:0] a, logic [13:0] b);
    miso_exp_t e;
    e.oe = 1'b0;
    e.d  = 1'b0;
    if (k >= 3 && k <= 16) begin
      e.oe = 1'b1;
      e.d  = a[16-k];
    end else if (k >= 19 && k <= 32) begin
      e.oe = 1'b1;
      e.d  = b[32-k];
    end
    return e;
  endfunction

  task automatic push_frame(input logic [13:0] a, input logic [13:0] b);
    sb_q.delete();
    for (int k = 1; k <= 34; k++) sb_q.push_back(frame_bit_model(k, a, b));
    got_a = '0;
    got_b = '0;
  endtask

  task automatic sck_cycle(input logic sample, input int k);
    miso_exp_t e;
    repeat (HALF) @(negedge clk);
    if (sample) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty edge %0d", k);
      end else begin
        e = sb_q.pop_front();
        check_output($sformatf("miso_edge%0d", k), {30'd0, spi_miso_oe, spi_miso}, {30'd0, e.oe, e.d});
        if (k >= 3 && k <= 16)  got_a = {got_a[12:0], spi_miso};
        if (k >= 19 && k <= 32) got_b = {got_b[12:0], spi_miso};
      end
    end
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic conv_start(input logic [13:0] a, input logic [13:0] b);
    @(negedge clk);
    sample_a = a;
    sample_b = b;
    adc_conv = 1'b1;
    repeat (5) @(negedge clk);
    adc_conv = 1'b0;
    push_frame(a, b);
  endtask

  task automatic run_edges(input int first, input int last);
    for (int k = first; k <= last; k++) sck_cycle(1'b1, k);
  endtask

  task automatic check_frame_end(input logic [13:0] a, input logic [13:0] b, input int exp_done, input int exp_count);
    repeat (10) @(negedge clk);
    check_output("captured_a", {18'd0, got_a}, {18'd0, a});
    check_output("captured_b", {18'd0, got_b}, {18'd0, b});
    check_output("frame_done_pulses", n_done, exp_done);
    check_output("conv_count", {16'd0, conv_count}, exp_count);
    check_output("busy_after_frame", {31'd0, busy}, 32'd0);
    check_output("oe_after_frame", {31'd0, spi_miso_oe}, 32'd0);
    check_output("scoreboard_drained", sb_q.size(), 32'd0);
  endtask

  // Drives one preamp command from the table and checks gains and pulses.
  task automatic apply_stimulus(input int row);
    amp_vec_t v;
    int       v0;
    int       e0;
    v  = vecs[row];
    v0 = n_valid;
    e0 = n_err;
    @(negedge clk);
    amp_shdn = v.shdn;
    repeat (3) @(negedge clk);
    amp_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < v.nbits; i++) begin
      spi_mosi = (i < 8) ? v.cmd[7-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    amp_cs = 1'b1;
    repeat (10) @(negedge clk);
    amp_shdn = 1'b0;
    repeat (5) @(negedge clk);
    check_output($sformatf("gain_a_row%0d", row), {28'd0, gain_a}, {28'd0, v.exp_a});
    check_output($sformatf("gain_b_row%0d", row), {28'd0, gain_b}, {28'd0, v.exp_b});
    check_output($sformatf("gain_valid_row%0d", row), n_valid - v0, v.exp_valid);
    check_output($sformatf("protocol_err_row%0d", row), n_err - e0, v.exp_err);
  endtask

  initial begin
    logic [13:0] ra;
    logic [13:0] rb;
    int          done_base;

    vecs[0] = '{8'h11, 8, 1'b0, 4'h1, 4'h1, 1, 0};
    vecs[1] = '{8'hA5, 7, 1'b0, 4'h1, 4'h1, 0, 1};
    vecs[2] = '{8'h3C, 8, 1'b0, 4'hC, 4'h3, 1, 0};
    vecs[3] = '{8'hFF, 9, 1'b0, 4'hC, 4'h3, 0, 1};
    vecs[4] = '{8'h7E, 8, 1'b1, 4'h0, 4'h0, 0, 0};
    vecs[5] = '{8'h96, 8, 1'b0, 4'h6, 4'h9, 1, 0};
    vecs[6] = '{8'h00, 0, 1'b0, 4'h6, 4'h9, 0, 1};

    enable   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    amp_cs   = 1'b1;
    amp_shdn = 1'b0;
    adc_conv = 1'b0;
    sample_a = '0;
    sample_b = '0;
    got_a    = '0;
    got_b    = '0;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);

    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_output("reset_miso", {31'd0, spi_miso}, 32'd0);
    check_output("reset_gain_a", {28'd0, gain_a}, 32'd0);
    check_output("reset_gain_b", {28'd0, gain_b}, 32'd0);
    check_output("reset_conv_count", {16'd0, conv_count}, 32'd0);

    for (int r = 0; r < 7; r++) apply_stimulus(r);

    $display("[TB] nominal frame");
    conv_start(14'h2C87, 14'h1555);
    check_output("busy_in_frame", {31'd0, busy}, 32'd1);
    run_edges(1, 34);
    check_frame_end(14'h2C87, 14'h1555, 1, 1);

    $display("[TB] aborted frame with coincident sck edge");
    conv_start(14'h0ABC, 14'h3210);
    run_edges(1, 19);
    done_base = n_done;
    @(negedge clk);
    sample_a = 14'h1234;
    sample_b = 14'h2DEF;
    adc_conv = 1'b1;
    spi_sck  = 1'b1;
    repeat (HALF) @(negedge clk);
    adc_conv = 1'b0;
    spi_sck  = 1'b0;
    push_frame(14'h1234, 14'h2DEF);
    check_output("no_done_on_abort", n_done, done_base);
    check_output("count_on_abort", {16'd0, conv_count}, 32'd1);
    run_edges(1, 34);
    check_frame_end(14'h1234, 14'h2DEF, 2, 2);

    $display("[TB] reset mid-frame");
    conv_start(14'h15AA, 14'h0F0F);
    run_edges(1, 9);
    @(negedge clk);
    spi_sck = 1'b1;
    enable  = 1'b1;
    #1;
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_output("rst_gain_a", {28'd0, gain_a}, 32'd0);
    check_output("rst_gain_b", {28'd0, gain_b}, 32'd0);
    check_output("rst_conv_count", {16'd0, conv_count}, 32'd0);
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    sb_q.delete();
    sck_cycle(1'b0, 0);
    sck_cycle(1'b0, 0);
    repeat (5) @(negedge clk);
    check_output("idle_sck_busy", {31'd0, busy}, 32'd0);
    check_output("idle_sck_oe", {31'd0, spi_miso_oe}, 32'd0);

    done_base = n_done;
    ra = 14'($urandom);
    rb = 14'($urandom);
    conv_start(ra, rb);
    run_edges(1, 34);
    check_frame_end(ra, rb, done_base + 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameters: DATA_W, default 14, ADC sample width; FRAME_LEN, default 34, SCK cycles per conversion frame; GAIN_W, default 8, preamp command width.
REQ-002 Ports, one clock; reset is asynchronous and active-high:
- clk  in  1  system clock, 50 MHz
- enable  in  1  asynchronous active-high reset
- spi_sck  in  1  SPI clock from master, asynchronous to clk, half-period >= 20 clk
- spi_mosi  in  1  master data, shifted into preamp register
- amp_cs  in  1  preamp select, active-low
- amp_shdn  in  1  preamp shutdown, active-high
- adc_conv  in  1  conversion start, rising edge
- sample_a  in  DATA_W  channel A value to report
- sample_b  in  DATA_W  channel B value to report
- spi_miso  out  1  ADC serial data
- spi_miso_oe  out  1  high while spi_miso is driven; low = hi-Z field
- gain_a  out  4  latched channel A gain code
- gain_b  out  4  latched channel B gain code
- gain_valid  out  1  one-clk pulse on gain update
- frame_done  out  1  one-clk pulse after rising edge FRAME_LEN
- busy  out  1  ADC frame in progress
- protocol_err  out  1  one-clk pulse on malformed preamp command
- conv_count  out  16  completed frames, wraps at 65535

Function
REQ-003 spi_sck, spi_mosi, amp_cs, adc_conv SHALL each pass a 2-flop synchronizer; edges detected on the synchronized signal (3 clk latency pin to edge pulse).
REQ-004 Preamp FSM states AMP_IDLE, AMP_SHIFT, AMP_LATCH; amp_cs falling -> AMP_SHIFT, bit counter cleared.
REQ-005 In AMP_SHIFT, each sck rising edge SHALL shift mosi into an 8-bit register MSB first and increment the bit counter (saturate at 15).
REQ-006 amp_cs rising -> AMP_LATCH; if count == 8: gain_b = bits[7:4], gain_a = bits[3:0], gain_valid pulses; else gains unchanged, protocol_err pulses; next cycle AMP_IDLE.
REQ-007 amp_shdn high SHALL force gain_a = gain_b = 0, hold AMP_IDLE, ignore shifts; no gain_valid.
REQ-008 ADC FSM states ADC_IDLE, ADC_FRAME, ADC_DONE; adc_conv rising SHALL capture sample_a/sample_b, clear rising-edge count k, enter ADC_FRAME, busy = 1.
REQ-009 Frame layout per rising edge k (1..34): k 1-2 hi-Z; 3-16 sample_a[13:0] MSB first; 17-18 hi-Z; 19-32 sample_b[13:0] MSB first; 33-34 hi-Z.
REQ-010 Bit for edge k SHALL be driven (spi_miso, spi_miso_oe) from the sck falling edge after edge k-1, held through edge k; spi_miso = 0 whenever spi_miso_oe = 0.
REQ-011 After rising edge 34: ADC_DONE for one clk (frame_done pulse, conv_count + 1), then ADC_IDLE, busy = 0, spi_miso_oe = 0.
REQ-012 adc_conv rising during ADC_FRAME SHALL abort and restart: new capture, k = 0, no frame_done, conv_count unchanged.
REQ-013 adc_conv edge and sck edge in same clk: conv handled, that sck edge not counted.
REQ-014 ADC framing SHALL count sck edges independently of amp_cs; sck edges in ADC_IDLE ignored.

Reset
REQ-015 enable high SHALL asynchronously set both FSMs idle, all counters, shift registers and synchronizers to 0, and every output to 0.
REQ-016 Reset mid-frame or mid-command SHALL discard partial data; after release, first action requires a fresh amp_cs falling or adc_conv rising.

Structure
REQ-017 Package adc_spi_pkg SHALL hold DATA_W, FRAME_LEN, GAIN_W, field boundaries (2, 16, 18, 32) and both FSM state encodings.
REQ-018 Sub-module spi_edge_sync (2-flop sync + rise/fall pulses) SHALL be instantiated once per input of REQ-003.

Verification
REQ-019 Command 8'b00010001, 8 sck cycles, amp_cs low -> gain_a = 1, gain_b = 1, one gain_valid pulse.
REQ-020 Command with 7 sck cycles -> protocol_err pulse, gains keep prior values.
REQ-021 sample_a = 14'h2C87, sample_b = 14'h1555, conv then 34 sck -> master captures exactly those values on edges 3-16 and 19-32, oe low on 1,2,17,18,33,34; frame_done once; conv_count = 1.
REQ-022 Second conv at edge 20 -> frame restarts with new samples, no frame_done for aborted frame, conv_count unchanged.
REQ-023 enable asserted at edge 10 -> all outputs 0 within same cycle; next full frame correct.
REQ-024 amp_shdn high during command -> gains 0, no gain_valid, no protocol_err.
